quadram_arbiter: RTL and testbench

Shares a single quadram port (32-bit data, 4-bit byte write enables, 11-bit word address, 1-cycle registered read) among N datapath requesters, such as the face-point, edge-point and averager stages of `subsurf`. Round-robin arbitration runs on every cycle. A locked burst mode keeps streaming stages on the port, and a watchdog bounds how long any one stage can hold it. Read data returns with a one-hot valid that identifies the requester, and an access counter feeds the top-level `word_count`.

---
 rtl/quadram_pkg.sv | 24 ++
 rtl/quadram_arbiter_rr_pick.sv | 47 ++++
 rtl/quadram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_quadram_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quadram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quadram_pkg
// Description : Shared widths, payload types and arbiter state encoding for
//               the quadram port arbiter and its pick helper.
// Revision    : 1.0 - initial release
// ============================================================================
package quadram_pkg;

    localparam int ADDR_WIDTH = 11;
    localparam int DATA_WIDTH = 32;
    localparam int WE_WIDTH   = 4;

    typedef logic [ADDR_WIDTH-1:0] quad_addr_t;
    typedef logic [DATA_WIDTH-1:0] quad_data_t;
    typedef logic [WE_WIDTH-1:0]   quad_we_t;

    typedef enum logic [0:0] {
        ARB_RR     = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/quadram_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority picker. Scans the request
//               vector starting at i_start, wrapping modulo N, and returns
//               the first set bit as a one-hot vector plus its index.
// Ports       : i_req     - request vector
//               i_start   - index with highest priority this cycle
//               o_onehot  - one-hot winner (all zero if no request)
//               o_idx     - winner index (zero if no request)
//               o_valid   - a winner exists
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        int j;
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        j        = 0;
        for (int k = 0; k < N; k++) begin
            // Walk the ring from i_start; i_start is always < N so a single
            // subtraction is enough to wrap.
            j = int'(i_start) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!o_valid && i_req[j]) begin
                o_valid     = 1'b1;
                o_onehot[j] = 1'b1;
                o_idx       = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/quadram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : quadram_arbiter
// Description : Shares one quadram port (1-cycle registered read) among N
//               requesters. Round-robin on every cycle, optional locked
//               bursts bounded by a MAX_LOCK watchdog, one-hot read-return
//               valid and a wrapping accepted-access counter.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               req, lock           - per-requester request / keep-ownership
//               req_a, req_we,
//               req_di              - packed per-requester payload slices
//               gnt                 - one-hot access accepted this cycle
//               rvalid, rdata       - one-hot read return owner and data
//               en, we, a, di       - RAM drive
//               ram_do              - RAM read data (the RAM's do pin)
//               busy                - any request or read returning
//               access_count        - accepted accesses, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module quadram_arbiter
    import quadram_pkg::*;
#(
    parameter int N        = 3,
    parameter int MAX_LOCK = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req,
    input  logic [N-1:0]            lock,
    input  logic [N*ADDR_WIDTH-1:0] req_a,
    input  logic [N*WE_WIDTH-1:0]   req_we,
    input  logic [N*DATA_WIDTH-1:0] req_di,
    output logic [N-1:0]            gnt,
    output logic [N-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    en,
    output logic [WE_WIDTH-1:0]     we,
    output logic [ADDR_WIDTH-1:0]   a,
    output logic [DATA_WIDTH-1:0]   di,
    input  logic [DATA_WIDTH-1:0]   ram_do,
    output logic                    busy,
    output logic [31:0]             access_count
);

    localparam int              c_idx_w    = $clog2(N);
    localparam logic [c_idx_w-1:0] c_last_rst = c_idx_w'(N - 1);
    localparam logic [8:0]      c_max_lock = 9'(MAX_LOCK);
    // A one-grant lock limit means the lock can never extend a burst.
    localparam bit              c_lock_en  = (MAX_LOCK > 1);

    arb_state_e         r_state, w_state_next;
    logic [c_idx_w-1:0] r_owner, w_owner_next;
    logic [c_idx_w-1:0] r_last, w_last_next;
    logic [7:0]         r_lock_cnt, w_lock_cnt_next;
    logic [N-1:0]       r_rvalid;
    logic [31:0]        r_count;
    quad_addr_t         r_a_hold;
    quad_data_t         r_di_hold;

    logic [N-1:0]       w_owner_mask;
    logic [N-1:0]       w_elig;
    logic [c_idx_w-1:0] w_start;
    logic [N-1:0]       w_win_oh;
    logic [c_idx_w-1:0] w_win_idx;
    logic               w_win_valid;
    logic               w_grant;
    logic               w_win_lock;
    quad_addr_t         w_sel_a;
    quad_we_t           w_sel_we;
    quad_data_t         w_sel_di;

    // ------------------------------------------------------------------
    // Eligibility: while locked only the owner may be picked.
    // ------------------------------------------------------------------
    always_comb begin
        w_owner_mask          = '0;
        w_owner_mask[r_owner] = 1'b1;
        w_elig  = (r_state == ARB_LOCKED) ? (req & w_owner_mask) : req;
        w_start = (r_last == c_last_rst) ? '0 : r_last + 1'b1;
    end

    rr_pick #(
        .N     (N),
        .IDX_W (c_idx_w)
    ) u_pick (
        .i_req    (w_elig),
        .i_start  (w_start),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    // ------------------------------------------------------------------
    // Winner payload and RAM drive. Reset suppresses every grant.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_a    = req_a[int'(w_win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_we   = req_we[int'(w_win_idx)*WE_WIDTH +: WE_WIDTH];
        w_sel_di   = req_di[int'(w_win_idx)*DATA_WIDTH +: DATA_WIDTH];
        w_win_lock = lock[w_win_idx];
        w_grant    = w_win_valid & ~rst;

        gnt = w_grant ? w_win_oh : '0;
        en  = w_grant;
        we  = w_grant ? w_sel_we : '0;
        // Address and data keep their last driven value on idle cycles so
        // the RAM pins do not toggle needlessly.
        a   = w_grant ? w_sel_a  : r_a_hold;
        di  = w_grant ? w_sel_di : r_di_hold;

        rvalid       = rst ? '0 : r_rvalid;
        rdata        = ram_do;
        busy         = ~rst & ((|req) | (|r_rvalid));
        access_count = rst ? 32'd0 : r_count;
    end

    // ------------------------------------------------------------------
    // Arbitration state: next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_last_next     = r_last;
        w_lock_cnt_next = r_lock_cnt;
        case (r_state)
            ARB_RR: begin
                if (w_win_valid) begin
                    if (w_win_lock && c_lock_en) begin
                        // Entering a burst leaves last alone; it is set to
                        // the owner when the burst ends.
                        w_state_next    = ARB_LOCKED;
                        w_owner_next    = w_win_idx;
                        w_lock_cnt_next = 8'd1;
                    end else begin
                        w_last_next = w_win_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                // Continue only if the owner is granted, still locking, and
                // this grant does not reach the watchdog limit. Any other
                // case (owner idle, lock dropped, limit hit) releases.
                if (w_win_valid && w_win_lock &&
                    (({1'b0, r_lock_cnt} + 9'd1) < c_max_lock)) begin
                    w_lock_cnt_next = r_lock_cnt + 8'd1;
                end else begin
                    w_state_next    = ARB_RR;
                    w_last_next     = r_owner;
                    w_lock_cnt_next = 8'd0;
                end
            end
            default: begin
                w_state_next    = ARB_RR;
                w_lock_cnt_next = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_RR;
            r_owner    <= '0;
            r_last     <= c_last_rst;
            r_lock_cnt <= 8'd0;
            r_rvalid   <= '0;
            r_count    <= 32'd0;
            r_a_hold   <= '0;
            r_di_hold  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_last     <= w_last_next;
            r_lock_cnt <= w_lock_cnt_next;
            // The RAM registers its read on this same edge, so the valid
            // lines up with do on the following cycle.
            r_rvalid   <= (w_grant && (w_sel_we == '0)) ? w_win_oh : '0;
            if (w_grant) begin
                r_count   <= r_count + 32'd1;
                r_a_hold  <= w_sel_a;
                r_di_hold <= w_sel_di;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quadram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_quadram_arbiter
// Description : Self-checking bench for quadram_arbiter: directed scenarios
//               plus randomized traffic against a behavioural model of the
//               arbitration rules and a shadow copy of RAM contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quadram_arbiter;
    import quadram_pkg::*;

    localparam int N        = 3;
    localparam int MAX_LOCK = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N-1:0]            req, lock;
    logic [N*ADDR_WIDTH-1:0] req_a;
    logic [N*WE_WIDTH-1:0]   req_we;
    logic [N*DATA_WIDTH-1:0] req_di;
    logic [N-1:0]            gnt, rvalid;
    logic [31:0]             rdata, di, ram_do, access_count;
    logic                    en, busy;
    logic [3:0]              we;
    logic [10:0]             a;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem    [0:2047];
    logic [31:0] shadow [0:2047];

    // model of the arbitration rules
    int          m_last, m_owner, m_burst;
    logic [31:0] m_count;
    logic [N-1:0] m_rvalid;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    quadram_arbiter #(.N(N), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .req_a(req_a), .req_we(req_we), .req_di(req_di),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .en(en), .we(we), .a(a), .di(di), .ram_do(ram_do),
        .busy(busy), .access_count(access_count)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // behavioural single-port RAM, 1-cycle registered read, byte writes
    always @(posedge clk) begin
        if (en) begin
            if (we == 4'h0) ram_do <= mem[a];
            else            mem[a] <= merge(mem[a], di, we);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req = '0; lock = '0; req_a = '0; req_we = '0; req_di = '0;
    endtask

    task automatic set_req(input int i, input logic lk, input logic [10:0] ad,
                           input logic [3:0] be, input logic [31:0] d);
        req[i] = 1'b1;
        lock[i] = lk;
        req_a[i*11 +: 11] = ad;
        req_we[i*4 +: 4] = be;
        req_di[i*32 +: 32] = d;
    endtask

    task automatic model_reset();
        m_last = N - 1; m_owner = -1; m_burst = 0;
        m_count = 32'd0; m_rvalid = '0; m_rdata = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // Who should win: the owner alone while a burst is active, otherwise the
    // first requester found walking the ring after the last unlocked winner.
    function automatic int model_pick(input logic [N-1:0] r);
        if (m_owner >= 0) return r[m_owner] ? m_owner : -1;
        for (int k = 1; k <= N; k++) begin
            int i = (m_last + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model by one cycle given the winner (or -1).
    task automatic model_commit(input int w, input logic lk, input logic rd,
                                input logic [31:0] rdv);
        m_rvalid = '0;
        if (w >= 0) begin
            m_count = m_count + 32'd1;
            if (rd) begin m_rvalid[w] = 1'b1; m_rdata = rdv; end
        end
        if (m_owner >= 0) begin
            // a burst is at most MAX_LOCK consecutive grants
            if (w >= 0 && lk && m_burst + 1 < MAX_LOCK) m_burst++;
            else begin m_last = m_owner; m_owner = -1; m_burst = 0; end
        end else if (w >= 0) begin
            if (lk && MAX_LOCK > 1) begin m_owner = w; m_burst = 1; end
            else m_last = w;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '1; lock = '1; req_we = '0;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL rst_gnt: got %b want 000", gnt); end
        n_cmp++; if (rvalid !== 3'b000) begin n_bad++; $display("FAIL rst_rvalid: got %b want 000", rvalid); end
        n_cmp++; if (en !== 1'b0) begin n_bad++; $display("FAIL rst_en: got %b want 0", en); end
        n_cmp++; if (we !== 4'h0) begin n_bad++; $display("FAIL rst_we: got %h want 0", we); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (access_count !== 32'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", access_count); end
        tick();
        rst = 1'b0;
        lock = '0;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL rst_first_gnt: got %b want 001", gnt); end
        tick();
        set_idle();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 11'(16'h200 + i), 4'h0, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp = 3'b001 << (k % 3);
            n_cmp++; if (gnt !== exp) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp); end
            if (k > 0) begin
                exp = 3'b001 << ((k - 1) % 3);
                n_cmp++; if (rvalid !== exp) begin n_bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, rvalid, exp); end
            end
            tick();
        end
        set_idle();
        @(negedge clk);
        n_cmp++; if (access_count !== 32'd6) begin n_bad++; $display("FAIL rr_count: got %0d want 6", access_count); end
        tick();
    endtask

    task automatic test_read_return();
        do_reset();
        mem[11'h010] = 32'hDEADBEEF;
        set_req(1, 1'b0, 11'h010, 4'h0, 32'd0);
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL rd_gnt: got %b want 010", gnt); end
        n_cmp++; if (en !== 1'b1 || a !== 11'h010 || we !== 4'h0) begin
            n_bad++; $display("FAIL rd_drive: got en=%b a=%h we=%h want en=1 a=010 we=0", en, a, we); end
        tick();
        set_idle();
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b010) begin n_bad++; $display("FAIL rd_rvalid: got %b want 010", rvalid); end
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", rdata); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy: got %b want 1", busy); end
        tick();
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b000 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rd_quiet: got rvalid=%b busy=%b want 000/0", rvalid, busy); end
        tick();
    endtask

    task automatic test_locked_burst();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            set_idle();
            set_req(2, (k < 4), 11'(16'h100 + k), 4'hF, 32'(k));
            if (k > 1) set_req(0, 1'b0, 11'h101, 4'h0, 32'd0);
            @(negedge clk);
            n_cmp++; if (gnt !== 3'b100) begin n_bad++; $display("FAIL burst_gnt[%0d]: got %b want 100", k, gnt); end
            tick();
        end
        set_idle();
        set_req(0, 1'b0, 11'h101, 4'h0, 32'd0);
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL burst_after: got %b want 001", gnt); end
        tick();
        set_idle();
    endtask

    task automatic test_watchdog();
        int n0;
        bit got1;
        n0 = 0; got1 = 1'b0;
        do_reset();
        set_req(0, 1'b1, 11'h300, 4'hF, 32'h1);
        set_req(1, 1'b0, 11'h301, 4'hF, 32'h2);
        for (int c = 0; c < 40 && !got1; c++) begin
            @(negedge clk);
            if (gnt === 3'b001) n0++;
            else if (gnt === 3'b010) got1 = 1'b1;
            tick();
        end
        set_idle();
        n_cmp++; if (got1 !== 1'b1) begin n_bad++; $display("FAIL wd_release: got no gnt[1] within 40 cycles, want one"); end
        n_cmp++; if (n0 !== 16) begin n_bad++; $display("FAIL wd_count: got %0d grants to 0 want 16", n0); end
    endtask

    task automatic test_byte_write();
        do_reset();
        mem[11'h020] = 32'hFFFFFFFF;
        set_req(0, 1'b0, 11'h020, 4'b0011, 32'h12345678);
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001 || we !== 4'b0011 || di !== 32'h12345678) begin
            n_bad++; $display("FAIL bw_write: got gnt=%b we=%b di=%h want 001/0011/12345678", gnt, we, di); end
        tick();
        set_req(0, 1'b0, 11'h020, 4'h0, 32'd0);
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL bw_rd_gnt: got %b want 001", gnt); end
        n_cmp++; if (rvalid !== 3'b000) begin n_bad++; $display("FAIL bw_no_rvalid: got %b want 000", rvalid); end
        tick();
        set_idle();
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b001) begin n_bad++; $display("FAIL bw_rvalid: got %b want 001", rvalid); end
        n_cmp++; if (rdata !== 32'hFFFF5678) begin n_bad++; $display("FAIL bw_data: got %h want ffff5678", rdata); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_req(1, 1'b1, 11'h010, 4'h0, 32'd0);
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL rmb_gnt: got %b want 010", gnt); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b000 || gnt !== 3'b000 || en !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rmb_in_rst: got rvalid=%b gnt=%b en=%b busy=%b want all 0", rvalid, gnt, en, busy); end
        n_cmp++; if (access_count !== 32'd0) begin n_bad++; $display("FAIL rmb_count: got %0d want 0", access_count); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 11'h010, 4'h0, 32'd0);
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b000) begin n_bad++; $display("FAIL rmb_rvalid: got %b want 000", rvalid); end
        n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL rmb_first: got %b want 001", gnt); end
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] pend, exp_g;
        logic [10:0]  pa  [N];
        logic [3:0]   pwe [N];
        logic [31:0]  pdi [N];
        logic         plk [N];
        logic         rd;
        logic [31:0]  rdv;
        int           w;
        do_reset();
        pend = '0;
        for (int i = 0; i < 16; i++) begin
            mem[11'h400 + 11'(i)] = $urandom;
            shadow[11'h400 + 11'(i)] = mem[11'h400 + 11'(i)];
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 55) begin
                    pend[i] = 1'b1;
                    pa[i]  = 11'h400 + 11'($urandom_range(0, 15));
                    pwe[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    pdi[i] = $urandom;
                    plk[i] = ($urandom_range(0, 99) < 35);
                end
            end
            set_idle();
            for (int i = 0; i < N; i++) if (pend[i]) set_req(i, plk[i], pa[i], pwe[i], pdi[i]);
            w = model_pick(pend);
            exp_g = '0;
            if (w >= 0) exp_g[w] = 1'b1;
            @(negedge clk);
            n_cmp++; if (gnt !== exp_g) begin n_bad++; $display("FAIL rnd_gnt@%0d: got %b want %b", cyc, gnt, exp_g); end
            n_cmp++; if (en !== (w >= 0)) begin n_bad++; $display("FAIL rnd_en@%0d: got %b want %b", cyc, en, (w >= 0)); end
            if (w >= 0) begin
                n_cmp++; if (a !== pa[w] || we !== pwe[w] || di !== pdi[w]) begin
                    n_bad++; $display("FAIL rnd_drive@%0d: got a=%h we=%h di=%h want a=%h we=%h di=%h",
                                      cyc, a, we, di, pa[w], pwe[w], pdi[w]); end
            end
            n_cmp++; if (rvalid !== m_rvalid) begin n_bad++; $display("FAIL rnd_rvalid@%0d: got %b want %b", cyc, rvalid, m_rvalid); end
            if (m_rvalid != '0) begin
                n_cmp++; if (rdata !== m_rdata) begin n_bad++; $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, rdata, m_rdata); end
            end
            n_cmp++; if (busy !== ((|pend) | (|m_rvalid))) begin
                n_bad++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, (|pend) | (|m_rvalid)); end
            n_cmp++; if (access_count !== m_count) begin n_bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, access_count, m_count); end
            rd = 1'b0; rdv = 32'd0;
            if (w >= 0) begin
                rd  = (pwe[w] == 4'h0);
                rdv = shadow[pa[w]];
                if (!rd) shadow[pa[w]] = merge(shadow[pa[w]], pdi[w], pwe[w]);
                pend[w] = 1'b0;
            end
            model_commit(w, (w >= 0) ? plk[w] : 1'b0, rd, rdv);
            tick();
        end
        set_idle();
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish by 1ms want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        ram_do = 32'd0;
        set_idle();
        model_reset();
        tick();
        test_reset();
        test_round_robin();
        test_read_return();
        test_locked_burst();
        test_watchdog();
        test_byte_write();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
